pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 112 +++++++++++
 tb/tb_pc_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with call/return control for an external return stack.
// Computes the next PC for SEQ/JMP/BRZ/CALL/RET and latches stack overflow/underflow.
module pc_sequencer #(
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned STACK_DEPTH = 2,
    parameter int unsigned RESET_PC    = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [2:0]        op,
    input  logic              cond,
    input  logic [ADDR_W-1:0] target,
    input  logic [ADDR_W-1:0] ret_addr,
    output logic [ADDR_W-1:0] pc,
    output logic              stk_push,
    output logic              stk_pop,
    output logic [ADDR_W-1:0] stk_in,
    output logic [1:0]        depth,
    output logic              flush,
    output logic              fault
);

    localparam logic [1:0]        DEPTH_MAX = 2'(STACK_DEPTH);
    localparam logic [ADDR_W-1:0] PC_RST    = ADDR_W'(RESET_PC);

    localparam logic [2:0] OP_JMP  = 3'b001;
    localparam logic [2:0] OP_BRZ  = 3'b010;
    localparam logic [2:0] OP_CALL = 3'b011;
    localparam logic [2:0] OP_RET  = 3'b100;

    typedef enum logic {S_RUN, S_FAULT} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] pc_inc;
    logic [1:0]        depth_next;
    logic              flush_next;
    logic              push_c;
    logic              pop_c;

    assign pc_inc = pc + ADDR_W'(1);
    assign stk_in = pc_inc;

    // Strobes are gated by rst_n so the stack never moves while the sequencer is held in reset.
    assign stk_push = push_c & rst_n;
    assign stk_pop  = pop_c & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_RUN;
            pc    <= PC_RST;
            depth <= 2'd0;
            flush <= 1'b0;
            fault <= 1'b0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            depth <= depth_next;
            flush <= flush_next;
            fault <= (state_next == S_FAULT);
        end
    end

    // Next-state, next-PC and stack strobe decode; inactive cycles hold everything.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        depth_next = depth;
        flush_next = 1'b0;
        push_c     = 1'b0;
        pop_c      = 1'b0;
        if (state == S_RUN && en) begin
            case (op)
                OP_JMP: begin
                    pc_next    = target;
                    flush_next = 1'b1;
                end
                OP_BRZ: begin
                    if (cond) begin
                        pc_next    = target;
                        flush_next = 1'b1;
                    end else begin
                        pc_next = pc_inc;
                    end
                end
                OP_CALL: begin
                    if (depth < DEPTH_MAX) begin
                        push_c     = 1'b1;
                        pc_next    = target;
                        depth_next = depth + 2'd1;
                        flush_next = 1'b1;
                    end else begin
                        state_next = S_FAULT;
                    end
                end
                OP_RET: begin
                    if (depth != 2'd0) begin
                        pop_c      = 1'b1;
                        pc_next    = ret_addr;
                        depth_next = depth - 2'd1;
                        flush_next = 1'b1;
                    end else begin
                        state_next = S_FAULT;
                    end
                end
                default: pc_next = pc_inc;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a reference model queues expected strobes and
// post-edge state for every driven step; each test task pops and compares them.
module tb_pc_sequencer;

    localparam int unsigned AW = 9;

    localparam logic [2:0] SEQ  = 3'b000;
    localparam logic [2:0] JMP  = 3'b001;
    localparam logic [2:0] BRZ  = 3'b010;
    localparam logic [2:0] CALL = 3'b011;
    localparam logic [2:0] RET  = 3'b100;

    typedef struct packed {
        logic          e;
        logic [2:0]    o;
        logic          c;
        logic [AW-1:0] t;
        logic [AW-1:0] r;
    } step_t;

    typedef struct packed {
        logic          push;
        logic          pop;
        logic [AW-1:0] sin;
    } strb_t;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [1:0]    depth;
        logic          flush;
        logic          fault;
    } obs_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [2:0]    op;
    logic          cond;
    logic [AW-1:0] target;
    logic [AW-1:0] ret_addr;
    logic [AW-1:0] pc;
    logic          stk_push;
    logic          stk_pop;
    logic [AW-1:0] stk_in;
    logic [1:0]    depth;
    logic          flush;
    logic          fault;

    int checks = 0;
    int passes = 0;

    logic [AW-1:0] m_pc;
    logic [1:0]    m_depth;
    logic          m_flush;
    logic          m_fault;

    strb_t strb_q[$];
    obs_t  obs_q[$];

    pc_sequencer #(.ADDR_W(AW), .STACK_DEPTH(2), .RESET_PC(0)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .op(op), .cond(cond),
        .target(target), .ret_addr(ret_addr), .pc(pc),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_in(stk_in),
        .depth(depth), .flush(flush), .fault(fault)
    );

    always #5 clk = ~clk;

    function automatic obs_t cur_obs();
        return '{pc: pc, depth: depth, flush: flush, fault: fault};
    endfunction

    function automatic strb_t cur_strb();
        return '{push: stk_push, pop: stk_pop, sin: stk_in};
    endfunction

    // Applies one step at the falling edge and queues the model's expectations.
    task automatic drive(input step_t s);
        strb_t es;
        obs_t  eo;
        logic  nf;
        @(negedge clk);
        en = s.e; op = s.o; cond = s.c; target = s.t; ret_addr = s.r;
        es.push = !m_fault && s.e && (s.o == CALL) && (m_depth < 2'd2);
        es.pop  = !m_fault && s.e && (s.o == RET) && (m_depth != 2'd0);
        es.sin  = m_pc + 9'd1;
        nf = 1'b0;
        if (!m_fault && s.e) begin
            case (s.o)
                JMP: begin m_pc = s.t; nf = 1'b1; end
                BRZ: if (s.c) begin m_pc = s.t; nf = 1'b1; end else m_pc = m_pc + 9'd1;
                CALL: if (m_depth < 2'd2) begin m_pc = s.t; m_depth = m_depth + 2'd1; nf = 1'b1; end
                      else m_fault = 1'b1;
                RET: if (m_depth != 2'd0) begin m_pc = s.r; m_depth = m_depth - 2'd1; nf = 1'b1; end
                     else m_fault = 1'b1;
                default: m_pc = m_pc + 9'd1;
            endcase
        end
        m_flush = nf;
        eo = '{pc: m_pc, depth: m_depth, flush: m_flush, fault: m_fault};
        strb_q.push_back(es);
        obs_q.push_back(eo);
        #1;
    endtask

    task automatic model_reset();
        m_pc = 9'd0; m_depth = 2'd0; m_flush = 1'b0; m_fault = 1'b0;
    endtask

    task automatic test_reset();
        obs_t  eo;
        strb_t got;
        @(negedge clk);
        rst_n = 1'b0; en = 1'b1; op = CALL; cond = 1'b0; target = 9'h0AA; ret_addr = 9'h0;
        model_reset();
        #1;
        eo = '{pc: 9'd0, depth: 2'd0, flush: 1'b0, fault: 1'b0};
        checks++;
        if (cur_obs() !== eo) $display("FAIL reset_state got %h exp %h", cur_obs(), eo);
        else passes++;
        @(posedge clk); #1;
        got = cur_strb();
        checks++;
        if (got.push !== 1'b0 || got.pop !== 1'b0 || cur_obs() !== eo)
            $display("FAIL reset_hold got push=%b pop=%b obs=%h exp push=0 pop=0 obs=%h",
                     got.push, got.pop, cur_obs(), eo);
        else passes++;
        #1 rst_n = 1'b1;
    endtask

    task automatic test_seq();
        step_t tbl[$];
        tbl = '{'{1'b1, SEQ, 1'b0, 9'h0, 9'h0}, '{1'b1, SEQ, 1'b0, 9'h0, 9'h0},
                '{1'b1, SEQ, 1'b0, 9'h0, 9'h0}};
        foreach (tbl[i]) begin
            strb_t es; obs_t eo;
            drive(tbl[i]);
            es = strb_q.pop_front();
            checks++;
            if (cur_strb() !== es) $display("FAIL seq_strobe[%0d] got %h exp %h", i, cur_strb(), es);
            else passes++;
            @(posedge clk); #1;
            eo = obs_q.pop_front();
            checks++;
            if (cur_obs() !== eo) $display("FAIL seq_state[%0d] got %h exp %h", i, cur_obs(), eo);
            else passes++;
        end
    endtask

    task automatic test_call_ret();
        step_t tbl[$];
        tbl = '{'{1'b1, JMP,  1'b0, 9'h005, 9'h0},
                '{1'b1, CALL, 1'b0, 9'h100, 9'h0},
                '{1'b1, CALL, 1'b0, 9'h180, 9'h0},
                '{1'b1, RET,  1'b0, 9'h0,   9'h101},
                '{1'b1, RET,  1'b0, 9'h0,   9'h006}};
        foreach (tbl[i]) begin
            strb_t es; obs_t eo;
            drive(tbl[i]);
            es = strb_q.pop_front();
            checks++;
            if (cur_strb() !== es) $display("FAIL callret_strobe[%0d] got %h exp %h", i, cur_strb(), es);
            else passes++;
            @(posedge clk); #1;
            eo = obs_q.pop_front();
            checks++;
            if (cur_obs() !== eo) $display("FAIL callret_state[%0d] got %h exp %h", i, cur_obs(), eo);
            else passes++;
        end
    endtask

    task automatic test_overflow();
        step_t tbl[$];
        tbl = '{'{1'b1, CALL, 1'b0, 9'h010, 9'h0},
                '{1'b1, CALL, 1'b0, 9'h020, 9'h0},
                '{1'b1, CALL, 1'b0, 9'h030, 9'h0},
                '{1'b1, SEQ,  1'b0, 9'h0,   9'h0},
                '{1'b1, JMP,  1'b0, 9'h044, 9'h0},
                '{1'b1, RET,  1'b0, 9'h0,   9'h055}};
        foreach (tbl[i]) begin
            strb_t es; obs_t eo;
            drive(tbl[i]);
            es = strb_q.pop_front();
            checks++;
            if (cur_strb() !== es) $display("FAIL ovf_strobe[%0d] got %h exp %h", i, cur_strb(), es);
            else passes++;
            @(posedge clk); #1;
            eo = obs_q.pop_front();
            checks++;
            if (cur_obs() !== eo) $display("FAIL ovf_state[%0d] got %h exp %h", i, cur_obs(), eo);
            else passes++;
        end
    endtask

    task automatic test_underflow();
        step_t s;
        strb_t es;
        obs_t  eo;
        s = '{1'b1, RET, 1'b0, 9'h0, 9'h077};
        drive(s);
        es = strb_q.pop_front();
        checks++;
        if (cur_strb() !== es) $display("FAIL udf_strobe got %h exp %h", cur_strb(), es);
        else passes++;
        @(posedge clk); #1;
        eo = obs_q.pop_front();
        checks++;
        if (cur_obs() !== eo) $display("FAIL udf_state got %h exp %h", cur_obs(), eo);
        else passes++;
    endtask

    task automatic test_wrap_branch();
        step_t tbl[$];
        tbl = '{'{1'b1, JMP, 1'b0, 9'h1FF, 9'h0},
                '{1'b1, SEQ, 1'b0, 9'h0,   9'h0},
                '{1'b1, BRZ, 1'b0, 9'h0AB, 9'h0},
                '{1'b1, BRZ, 1'b1, 9'h050, 9'h0}};
        foreach (tbl[i]) begin
            strb_t es; obs_t eo;
            drive(tbl[i]);
            es = strb_q.pop_front();
            checks++;
            if (cur_strb() !== es) $display("FAIL wrap_strobe[%0d] got %h exp %h", i, cur_strb(), es);
            else passes++;
            @(posedge clk); #1;
            eo = obs_q.pop_front();
            checks++;
            if (cur_obs() !== eo) $display("FAIL wrap_state[%0d] got %h exp %h", i, cur_obs(), eo);
            else passes++;
        end
    endtask

    task automatic test_back_to_back();
        step_t tbl[$];
        tbl = '{'{1'b1, JMP,    1'b0, 9'h010, 9'h0},
                '{1'b1, JMP,    1'b0, 9'h020, 9'h0},
                '{1'b1, BRZ,    1'b1, 9'h030, 9'h0},
                '{1'b1, CALL,   1'b0, 9'h040, 9'h0},
                '{1'b1, RET,    1'b0, 9'h0,   9'h099},
                '{1'b1, 3'b101, 1'b1, 9'h0EE, 9'h0},
                '{1'b1, 3'b110, 1'b1, 9'h0EE, 9'h0},
                '{1'b1, 3'b111, 1'b1, 9'h0EE, 9'h0}};
        foreach (tbl[i]) begin
            strb_t es; obs_t eo;
            drive(tbl[i]);
            es = strb_q.pop_front();
            checks++;
            if (cur_strb() !== es) $display("FAIL b2b_strobe[%0d] got %h exp %h", i, cur_strb(), es);
            else passes++;
            @(posedge clk); #1;
            eo = obs_q.pop_front();
            checks++;
            if (cur_obs() !== eo) $display("FAIL b2b_state[%0d] got %h exp %h", i, cur_obs(), eo);
            else passes++;
        end
    endtask

    task automatic test_stall_reset();
        step_t tbl[$];
        obs_t  eo;
        tbl = '{'{1'b1, CALL, 1'b0, 9'h0AA, 9'h0},
                '{1'b0, CALL, 1'b0, 9'h0BB, 9'h0},
                '{1'b0, CALL, 1'b0, 9'h0BB, 9'h0},
                '{1'b0, CALL, 1'b0, 9'h0BB, 9'h0},
                '{1'b0, CALL, 1'b0, 9'h0BB, 9'h0}};
        foreach (tbl[i]) begin
            strb_t es;
            drive(tbl[i]);
            es = strb_q.pop_front();
            checks++;
            if (cur_strb() !== es) $display("FAIL stall_strobe[%0d] got %h exp %h", i, cur_strb(), es);
            else passes++;
            @(posedge clk); #1;
            eo = obs_q.pop_front();
            checks++;
            if (cur_obs() !== eo) $display("FAIL stall_state[%0d] got %h exp %h", i, cur_obs(), eo);
            else passes++;
        end
        // Reset pulse between edges must clear state without waiting for a clock.
        @(negedge clk);
        en = 1'b1; op = SEQ;
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        eo = '{pc: 9'd0, depth: 2'd0, flush: 1'b0, fault: 1'b0};
        checks++;
        if (cur_obs() !== eo) $display("FAIL async_reset got %h exp %h", cur_obs(), eo);
        else passes++;
        rst_n = 1'b1;
        // First edge after release executes the presented SEQ.
        @(posedge clk); #1;
        m_pc = 9'd1;
        eo = '{pc: m_pc, depth: m_depth, flush: 1'b0, fault: 1'b0};
        checks++;
        if (cur_obs() !== eo) $display("FAIL first_edge got %h exp %h", cur_obs(), eo);
        else passes++;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; op = SEQ; cond = 1'b0; target = '0; ret_addr = '0;
        model_reset();
        test_reset();
        test_seq();
        test_call_ret();
        test_overflow();
        test_reset();
        test_underflow();
        test_reset();
        test_wrap_branch();
        test_back_to_back();
        test_reset();
        test_stall_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
